// File: rtl/bist_ctrl_c432.sv
// Session controller for the c432 logic-BIST loop (LFSR -> CUT -> 4-bit MISR).
// Sequences seed, NUM_WINDOWS compaction windows and per-window signature checks.
module bist_ctrl_c432 #(
  parameter int WINDOW      = 7,
  parameter int NUM_WINDOWS = 4,
  parameter int IDX_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       sig,
  input  logic [3:0]       golden_sig,
  output logic             test_mode,
  output logic             lfsr_load,
  output logic             lfsr_en,
  output logic             misr_load,
  output logic             misr_en,
  output logic [IDX_W-1:0] win_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] fail_idx
);

  localparam int                CNT_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0]  WIN_LAST = IDX_W'(NUM_WINDOWS - 1);

  typedef enum logic [2:0] {IDLE, SEED, RUN, CAPTURE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] pat_cnt;
  logic             fail_flag;
  logic             mismatch;

  assign mismatch = (sig != golden_sig);

  // Outputs are registered: each branch drives the values for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_cnt   <= '0;
      fail_flag <= 1'b0;
      test_mode <= 1'b0;
      lfsr_load <= 1'b0;
      lfsr_en   <= 1'b0;
      misr_load <= 1'b0;
      misr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      win_idx   <= '0;
      fail_idx  <= '0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in
      // the case below; the last non-blocking write in the block wins.
      test_mode <= 1'b0;
      lfsr_load <= 1'b0;
      lfsr_en   <= 1'b0;
      misr_load <= 1'b0;
      misr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;

      if (abort) begin
        state     <= IDLE;
        pat_cnt   <= '0;
        fail_flag <= 1'b0;
        pass      <= 1'b0;
        win_idx   <= '0;
        fail_idx  <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state     <= SEED;
              lfsr_load <= 1'b1;
              misr_load <= 1'b1;
              test_mode <= 1'b1;
              busy      <= 1'b1;
              pat_cnt   <= '0;
              fail_flag <= 1'b0;
              pass      <= 1'b0;
              win_idx   <= '0;
              fail_idx  <= '0;
            end else if (state == DONE) begin
              done <= 1'b1;
            end
          end

          SEED: begin
            state     <= RUN;
            pat_cnt   <= '0;
            test_mode <= 1'b1;
            busy      <= 1'b1;
            lfsr_en   <= 1'b1;
            misr_en   <= 1'b1;
          end

          RUN: begin
            test_mode <= 1'b1;
            busy      <= 1'b1;
            if (pat_cnt == CNT_LAST) begin
              state     <= CAPTURE;
              pat_cnt   <= '0;
              misr_load <= 1'b1;
            end else begin
              pat_cnt <= pat_cnt + CNT_W'(1);
              lfsr_en <= 1'b1;
              misr_en <= 1'b1;
            end
          end

          CAPTURE: begin
            // Only the first failing window is recorded; the flag is sticky.
            if (mismatch && !fail_flag) begin
              fail_flag <= 1'b1;
              fail_idx  <= win_idx;
            end
            if (win_idx == WIN_LAST) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= !(fail_flag || mismatch);
            end else begin
              state     <= RUN;
              win_idx   <= win_idx + IDX_W'(1);
              test_mode <= 1'b1;
              busy      <= 1'b1;
              lfsr_en   <= 1'b1;
              misr_en   <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bist_ctrl_c432.sv
// Self-checking bench for bist_ctrl_c432: emulates the LFSR/CUT/MISR datapath and a
// golden ROM, and compares every output each cycle against a cycle-number model.
module tb_bist_ctrl_c432;

  localparam int W  = 7;
  localparam int NW = 4;
  localparam int IW = 2;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [3:0]    sig;
  logic [3:0]    golden_sig;
  logic          test_mode, lfsr_load, lfsr_en, misr_load, misr_en;
  logic [IW-1:0] win_idx;
  logic          busy, done, pass;
  logic [IW-1:0] fail_idx;

  int total = 0;
  int bad   = 0;

  bist_ctrl_c432 #(.WINDOW(W), .NUM_WINDOWS(NW), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .sig        (sig),
    .golden_sig (golden_sig),
    .test_mode  (test_mode),
    .lfsr_load  (lfsr_load),
    .lfsr_en    (lfsr_en),
    .misr_load  (misr_load),
    .misr_en    (misr_en),
    .win_idx    (win_idx),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_idx   (fail_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath emulation and golden ROM ----------------
  logic [7:0]    seed_v;
  logic [3:0]    key_v;
  logic [NW-1:0] fmask_cur;
  logic [3:0]    rom [NW];
  logic [7:0]    lfsr;
  logic [3:0]    misr;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [3:0] cut(input logic [7:0] l, input logic [3:0] k);
    return l[7:4] ^ l[3:0] ^ k ^ {l[0], l[7], l[2], l[5]};
  endfunction

  function automatic logic [3:0] misr_step(input logic [3:0] m, input logic [3:0] d);
    return {m[2:0], m[3] ^ m[2]} ^ d;
  endfunction

  // Signature of window w: the stream is continuous, so window w sees patterns w*W .. w*W+W-1.
  function automatic logic [3:0] golden_of(input int w, input logic [7:0] s, input logic [3:0] k);
    logic [7:0] l;
    logic [3:0] m;
    l = s;
    for (int i = 0; i < w * W; i++) l = lfsr_step(l);
    m = 4'b1101;
    for (int i = 0; i < W; i++) begin
      m = misr_step(m, cut(l, k));
      l = lfsr_step(l);
    end
    return m;
  endfunction

  always @(posedge clk) begin
    if (lfsr_load)    lfsr <= seed_v;
    else if (lfsr_en) lfsr <= lfsr_step(lfsr);
    if (misr_load)    misr <= 4'b1101;
    else if (misr_en) misr <= misr_step(misr, cut(lfsr, key_v));
  end

  assign sig        = misr;
  assign golden_sig = rom[win_idx] ^ {3'b000, fmask_cur[win_idx]};

  task automatic prepare(input logic [NW-1:0] fm);
    seed_v    = 8'($urandom_range(1, 255));
    key_v     = 4'($urandom);
    fmask_cur = fm;
    for (int w = 0; w < NW; w++) rom[w] = golden_of(w, seed_v, key_v);
  endtask

  // ---------------- cycle-level reference model ----------------
  logic [11:0] obs;
  assign obs = {test_mode, lfsr_load, lfsr_en, misr_load, misr_en, busy, done, pass,
                win_idx, fail_idx};

  function automatic logic [IW-1:0] first_fail(input logic [NW-1:0] fm, input int below);
    logic [IW-1:0] f;
    f = '0;
    for (int i = below - 1; i >= 0; i--) if (fm[i]) f = IW'(i);
    return f;
  endfunction

  // Expected outputs in cycle t of a session (t=1 is SEED), from the cycle arithmetic alone.
  function automatic logic [11:0] expect_at(input int t, input logic [NW-1:0] fm);
    int u, w, r;
    if (t <= 0) return '0;
    if (t == 1) return {6'b110101, 2'b00, IW'(0), IW'(0)};
    u = t - 2;
    w = u / (W + 1);
    r = u % (W + 1);
    if (w >= NW) return {6'b000000, 1'b1, (fm == '0), IW'(NW - 1), first_fail(fm, NW)};
    if (r < W)   return {6'b101011, 2'b00, IW'(w), first_fail(fm, w)};
    return {6'b100101, 2'b00, IW'(w), first_fail(fm, w)};
  endfunction

  task automatic watch(input string name, input int first, input int last,
                       input logic [NW-1:0] fm);
    logic [11:0] e;
    for (int t = first; t <= last; t++) begin
      @(negedge clk);
      e = expect_at(t, fm);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL %s cycle=%0d got=%b want=%b", name, t, obs, e);
      end
    end
  endtask

  task automatic launch(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #3;
    total++;
    if (obs !== 12'b0) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", obs, 12'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    watch("idle_after_reset", -3, -1, '0);
  endtask

  task automatic test_pass;
    prepare('0);
    launch(1'b0);
    watch("pass_session", 1, 36, '0);
  endtask

  task automatic test_single_fault;
    prepare(4'b0100);
    launch(1'b0);
    watch("single_fault", 1, 35, 4'b0100);
  endtask

  task automatic test_multi_fault;
    prepare(4'b1010);
    launch(1'b0);
    watch("multi_fault", 1, 35, 4'b1010);
  endtask

  task automatic test_abort;
    prepare('0);
    launch(1'b0);
    watch("pre_abort", 1, 12, '0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== 12'b0) begin
      bad++;
      $display("FAIL abort_clears got=%b want=%b", obs, 12'b0);
    end
    abort = 1'b0;
    start = 1'b0;
    watch("idle_after_abort", -2, -1, '0);
    prepare('0);
    launch(1'b0);
    watch("post_abort_session", 1, 35, '0);
  endtask

  task automatic test_start_hold;
    logic [NW-1:0] fm;
    fm = NW'($urandom);
    prepare(fm);
    launch(1'b1);
    watch("held_start", 1, 34, fm);
    // start is still high in DONE, so the next edge restarts into SEED.
    watch("restart_seed", 1, 1, fm);
    start = 1'b0;
    watch("restarted_session", 2, 35, fm);
  endtask

  task automatic test_back_to_back;
    logic [NW-1:0] fm;
    for (int s = 0; s < 3; s++) begin
      fm = NW'($urandom);
      prepare(fm);
      launch(1'b0);
      watch("random_session", 1, 34, fm);
    end
  endtask

  task automatic test_async_reset;
    prepare('0);
    launch(1'b0);
    watch("pre_reset", 1, 9, '0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 12'b0) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", obs, 12'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    watch("idle_after_async", -4, -1, '0);
    prepare(4'b0001);
    launch(1'b0);
    watch("post_reset_session", 1, 35, 4'b0001);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    seed_v    = 8'h01;
    key_v     = 4'h0;
    fmask_cur = '0;
    for (int w = 0; w < NW; w++) rom[w] = 4'h0;
    test_reset();
    test_pass();
    test_single_fault();
    test_multi_fault();
    test_abort();
    test_start_hold();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bist_ctrl_c432.md
# bist_ctrl_c432

Session controller for the c432 logic-BIST loop: pattern LFSR → CUT → 4-bit MISR. It sequences one self-test session: seeds the LFSR and MISR, runs `NUM_WINDOWS` compaction windows of `WINDOW` cycles each, and checks each window's signature against a golden value supplied by an external ROM. It reports busy, done and pass/fail, plus the index of the first failing window. It sits between the test-access logic (start/abort) and the BIST datapath (LFSR, MISR, test-mode mux).

## Interface
- `WINDOW`, 7: patterns compacted per signature window (≥1).
- `NUM_WINDOWS`, 4: signature windows per session (≥1).
- `IDX_W`, 2: width of the window index; must satisfy 2^IDX_W ≥ NUM_WINDOWS.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: session request, sampled in IDLE or DONE.
- `abort` input 1: cancels any session.
- `sig` input 4: current MISR contents.
- `golden_sig` input 4: expected signature for `win_idx`, valid combinationally.
- `test_mode` output 1: selects LFSR patterns into the CUT.
- `lfsr_load` output 1: LFSR loads its seed.
- `lfsr_en` output 1: LFSR advances.
- `misr_load` output 1: MISR loads seed 4'b1101.
- `misr_en` output 1: MISR compacts.
- `win_idx` output IDX_W: current window, which addresses the golden ROM.
- `busy` output 1: session in progress.
- `done` output 1: session complete; level output.
- `pass` output 1: all windows matched; valid while `done` is high.
- `fail_idx` output IDX_W: first mismatching window; valid when `done` is high and `pass` is low.

## Operation
- FSM states: IDLE, SEED, RUN, CAPTURE, DONE.
- **IDLE**
  - All outputs are 0.
  - `start` moves the FSM to SEED.
- **SEED** (1 cycle)
  - Asserts `lfsr_load`, `misr_load`, `test_mode` and `busy`.
  - Clears `win_idx`, the pattern counter, the sticky fail flag and `fail_idx`.
  - Next state is RUN.
- **RUN** (`WINDOW` cycles)
  - Asserts `lfsr_en`, `misr_en`, `test_mode` and `busy`.
  - The pattern counter counts 0..WINDOW-1. At the terminal count the FSM moves to CAPTURE and the counter wraps to 0.
- **CAPTURE** (1 cycle)
  - `lfsr_en` and `misr_en` are low. `misr_load` is high, so the MISR reseeds at the closing edge.
  - Compares `sig` with `golden_sig` in this cycle. On mismatch with the sticky flag clear: set the flag and record `fail_idx <= win_idx`. Later mismatches do not overwrite `fail_idx`.
  - If `win_idx == NUM_WINDOWS-1`, go to DONE. Otherwise increment `win_idx` and return to RUN.
- **DONE**
  - `done` = 1 and `pass` = ~sticky flag. `busy`, `test_mode` and all enables are 0.
  - `win_idx`, `pass` and `fail_idx` hold.
  - `start` moves the FSM to SEED, which clears the results.
- **abort**, in any state: the FSM goes to IDLE at the next edge and all outputs clear. `abort` has priority over `start`.
- `start` in SEED, RUN or CAPTURE is ignored.
- The LFSR never reloads between windows; the pattern stream is continuous across the session.

## Timing
- Reset (`rst_n` low, asynchronous): state is IDLE and every output is 0, including `win_idx`, `pass` and `fail_idx`.
- Reset release is synchronous to the first rising edge after `rst_n` goes high.
- Cycle numbering: the edge that samples `start` ends cycle 0.
  - Cycle 1: SEED.
  - Cycles 2..WINDOW+1: RUN for window 0.
  - Cycle WINDOW+2: CAPTURE for window 0.
- Session length is 1 + NUM_WINDOWS·(WINDOW+1) cycles. `done` first rises in cycle 2 + NUM_WINDOWS·(WINDOW+1), which is cycle 34 at defaults.
- All outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.
- `sig` and `golden_sig` only need to be stable in CAPTURE cycles.
- Reset asserted mid-session: immediate return to IDLE. No partial results are retained.

## Test plan
- **Pass session:** reset, then pulse `start`; a model MISR matches the golden ROM.
  - `busy` is high for cycles 1–33 and `done`=1, `pass`=1 from cycle 34.
  - `lfsr_load` is high only in cycle 1. `misr_load` is high in cycles 1, 9, 17, 25 and 33.
- **Single fault:** force a `sig` mismatch in window 2 only → `done`=1, `pass`=0, `fail_idx`=2.
- **Multiple faults:** mismatches in windows 1 and 3 → `fail_idx`=1 (first fail is kept).
- **Abort:** assert `abort` in cycle 12 (RUN, window 1), together with `start` → IDLE at the next edge and all outputs 0. A fresh `start` then gives a full 33-cycle session.
- **Start handling:** `start` held high through a session is ignored while busy. Its next sampling in DONE restarts: `done` falls and `pass`/`fail_idx` clear in SEED.
- **Async reset:** drop `rst_n` mid-CAPTURE, between edges → outputs go to 0 without waiting for a clock edge. After release, the block stays in IDLE until `start`.
